if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//   Instruction fetch stage feeding id_stage. Owns the PC, issues in-order
//   32-bit fetch requests to instruction memory with up to DEPTH requests in
//   flight, buffers returned words in a DEPTH-entry FIFO, and presents
//   {inst, inst_pc} to decode under a valid/ready handshake. Redirects from
//   EX (branch/jump) flush the buffer and discard stale responses.
// PARAMETERS
//   PC_RESET  64'h0000_0000_8000_0000  PC value loaded by reset
//   DEPTH     2                        FIFO entries = max requests in flight (2..4)
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   rst             in   1   synchronous reset, active-low (0 = reset)
//   redirect_valid  in   1   EX requests a PC change this cycle
//   redirect_pc     in   64  new fetch target; bits [1:0] are ignored and forced to 0
//   imem_req        out  1   fetch request valid
//   imem_addr       out  64  fetch address (word aligned)
//   imem_ready      in   1   memory accepts request when imem_req & imem_ready
//   imem_rvalid     in   1   response valid; responses return in request order
//   imem_rdata      in   32  response instruction word
//   inst_valid      out  1   FIFO head valid for decode
//   inst            out  32  instruction to id_stage; 32'h0000_0013 (NOP) when !inst_valid
//   inst_pc         out  64  PC of inst; 0 when !inst_valid
//   id_ready        in   1   decode consumes head when inst_valid & id_ready
// BEHAVIOUR
//   Reset (rst=0 at edge): pc=PC_RESET, FIFO empty, in_flight=0, stale=0, state=FETCH.
//     Outputs during/after reset: imem_req=0, inst_valid=0, inst=NOP, inst_pc=0.
//   imem_req=1 is combinational from the state and counters (no memory-input
//     dependence) when state=FETCH & (count+in_flight)<DEPTH & !redirect_valid.
//     imem_addr=pc. On accept: pc<=pc+4, in_flight+1.
//   Request held stable (addr unchanged) while imem_req & !imem_ready.
//   Response: imem_rvalid with stale=0 -> push {rdata, pc-of-request} into FIFO,
//     in_flight-1. FIFO entry visible as inst_valid the next cycle (no bypass);
//     min latency request accept -> inst_valid = 1 cycle after rvalid.
//   A response always has FIFO space (credit rule); rvalid with in_flight=0 is
//     illegal and ignored.
//   Pop: inst_valid & id_ready -> head removed at edge. Push+pop same cycle allowed.
//   FSM states:
//     FETCH: normal issue. redirect_valid -> pc<=redirect_pc, FIFO flushed,
//       stale<=in_flight (minus any response arriving this cycle, which is dropped),
//       in_flight<=0; next = (stale'!=0) ? FLUSH : FETCH.
//     FLUSH: no requests; each rvalid drops data, stale-1; stale reaches 0 -> FETCH.
//       redirect_valid in FLUSH: pc updated, stay in FLUSH.
//   Redirect has priority over pop, push and request in the same cycle; a request
//     is never issued in the redirect cycle; first new request next cycle (FETCH)
//     or the cycle after stale reaches 0.
//   inst_valid=0 in the redirect cycle's next cycle (FIFO emptied).
//   pc arithmetic: 64-bit, wraps modulo 2^64 (FFFF_FFFF_FFFF_FFFC+4 -> 0).
//   FIFO: circular pointers modulo DEPTH, count 0..DEPTH; full never overruns.
//   Reset mid-operation: all counters cleared; responses to pre-reset requests
//     arriving after reset are ignored (in_flight=0).
// TESTING
//   1 Reset release, imem_ready=1, rvalid 1 cycle later: req addrs 8000_0000,
//     8000_0004...; inst_valid first high 2 cycles after first accept, inst_pc=8000_0000.
//   2 id_ready=0 with DEPTH=2: after 2 accepts imem_req drops, FIFO holds 2
//     entries; id_ready=1 one cycle -> one pop, exactly one new request issued.
//   3 imem_ready low 3 cycles: imem_req/imem_addr=8000_0000 held; single accept.
//   4 Redirect to 8000_0102 with 2 in flight: FLUSH, both responses dropped,
//     next req addr 8000_0100, no stale inst reaches decode.
//   5 Redirect same cycle as rvalid and pop: response dropped, FIFO empty next
//     cycle, stale=in_flight-1.
//   6 redirect_pc=FFFF_FFFF_FFFF_FFFC: addrs ...FFFC then 0000_0000_0000_0000;
//     mid-stream rst=0 -> outputs NOP/0, next req at PC_RESET.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage feeding id_stage. Owns the PC, issues in-order
//   word fetches to instruction memory with up to DEPTH requests in flight,
//   buffers returned words in a DEPTH-entry FIFO and hands {inst, inst_pc}
//   to decode under a valid/ready handshake. A redirect from EX empties the
//   buffer and arranges for responses that are still in flight to be dropped.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous reset, active-low
//   redirect_valid  EX requests a PC change this cycle
//   redirect_pc     new fetch target (low two bits ignored)
//   imem_req        fetch request valid
//   imem_addr       fetch address (word aligned)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid, responses return in request order
//   imem_rdata      response instruction word
//   inst_valid      FIFO head valid for decode
//   inst            head instruction, NOP when not valid
//   inst_pc         PC of head instruction, 0 when not valid
//   id_ready        decode consumes the head this cycle
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        id_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        FLUSH
    } state_t;

    state_t        state;
    logic [63:0]   pc;
    logic [31:0]   fifo_inst [DEPTH];
    logic [63:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] stale;

    logic          accept;
    logic          rsp_take;
    logic          pop;
    logic [CW:0]   occupancy;
    logic [63:0]   resp_pc;
    logic [CW-1:0] redirect_stale;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every buffered word plus every outstanding request holds one FIFO
    // credit, so a response can always be written when it arrives.
    assign occupancy = {1'b0, count} + {1'b0, in_flight};
    assign imem_req  = rst && (state == FETCH) && !redirect_valid
                       && (occupancy < (CW + 1)'(DEPTH));
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;

    // Responses outside FETCH, or with nothing outstanding, never reach the FIFO.
    assign rsp_take  = (state == FETCH) && imem_rvalid && (in_flight != '0);

    // Requests since the last redirect are sequential, so the oldest
    // outstanding one sits in_flight words behind the current PC.
    assign resp_pc   = pc - (64'(in_flight) << 2);

    assign inst_valid = rst && (count != '0);
    assign inst       = inst_valid ? fifo_inst[rd_ptr] : NOP;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : 64'd0;
    assign pop        = inst_valid && id_ready;

    // Number of responses still owed by memory after a redirect this cycle;
    // any response arriving in the redirect cycle itself is already dropped.
    always_comb begin
        redirect_stale = stale;
        if (state == FETCH) begin
            redirect_stale = in_flight - CW'(rsp_take);
        end else if (imem_rvalid && (stale != '0)) begin
            redirect_stale = stale - CW'(1);
        end
    end

    // FIFO storage is plain data and needs no reset; validity lives in count.
    always_ff @(posedge clk) begin
        if (rsp_take && !redirect_valid) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    // Control FSM. A redirect wins over request, push and pop in the same
    // cycle; FLUSH swallows owed responses before issuing resumes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= PC_RESET;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= '0;
            stale     <= '0;
        end else if (redirect_valid) begin
            pc        <= {redirect_pc[63:2], 2'b00};
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= '0;
            stale     <= redirect_stale;
            state     <= ((state == FLUSH) || (redirect_stale != '0)) ? FLUSH : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc <= pc + 64'd4;
                    end
                    in_flight <= in_flight + CW'(accept) - CW'(rsp_take);
                    if (rsp_take) begin
                        wr_ptr <= next_ptr(wr_ptr);
                    end
                    if (pop) begin
                        rd_ptr <= next_ptr(rd_ptr);
                    end
                    case ({rsp_take, pop})
                        2'b10:   count <= count + CW'(1);
                        2'b01:   count <= count - CW'(1);
                        default: count <= count;
                    endcase
                end
                FLUSH: begin
                    stale <= redirect_stale;
                    if (redirect_stale == '0) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
